// File: rtl/channel_err_injector_if.sv
// Bundle of the channel-model data path between the convolutional encoder and the Viterbi
// decoder.
//   master : the side driving symbols in and reading statistics (testbench / encoder side)
//   slave  : channel_err_injector
// Signals:
//   valid_i, sym_i      clean encoder symbol and its qualifier
//   mode_i              0 pass-through, 1 single-bit, 2 random mask, 3 burst
//   burst_len_i         burst length in symbols (mode 3; 0 behaves as 1)
//   clr_i               synchronous clear of the statistics counters
//   force_i             only with ERR_INJ_FORCE_EN: forces a trigger on a valid symbol
//   valid_o, sym_o      corrupted symbol, one cycle after the input
//   err_mask_o          mask applied to the current sym_o
//   sym_ct_o            valid symbols passed (wraps)
//   bit_err_ct_o        total flipped bits (saturates)
interface channel_err_injector_if #(
   parameter int unsigned SYM_W = 2,
   parameter int unsigned CNT_W = 32
);
   logic             valid_i;
   logic [SYM_W-1:0] sym_i;
   logic [1:0]       mode_i;
   logic [3:0]       burst_len_i;
   logic             clr_i;
`ifdef ERR_INJ_FORCE_EN
   logic             force_i;
`endif
   logic             valid_o;
   logic [SYM_W-1:0] sym_o;
   logic [SYM_W-1:0] err_mask_o;
   logic [CNT_W-1:0] sym_ct_o;
   logic [CNT_W-1:0] bit_err_ct_o;

   modport master (
`ifdef ERR_INJ_FORCE_EN
      output force_i,
`endif
      output valid_i, sym_i, mode_i, burst_len_i, clr_i,
      input  valid_o, sym_o, err_mask_o, sym_ct_o, bit_err_ct_o
   );

   modport slave (
`ifdef ERR_INJ_FORCE_EN
      input  force_i,
`endif
      input  valid_i, sym_i, mode_i, burst_len_i, clr_i,
      output valid_o, sym_o, err_mask_o, sym_ct_o, bit_err_ct_o
   );
endinterface

// File: rtl/channel_err_injector.sv
// Channel model injecting bit errors into SYM_W-bit encoded symbols. A 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11+1), stepped once per valid symbol, fires a trigger when its low
// RATE_BITS bits are all ones. Modes: pass-through, MSB flip, random mask, MSB-flip burst.
// Symbol and flipped-bit statistics are kept on chip.
// Ports:
//   clk     clock
//   rst     asynchronous active-low reset
//   bus_io  channel_err_injector_if.slave (symbol in/out, mode, statistics)
// Optional feature: define ERR_INJ_FORCE_EN to add bus_io.force_i, which forces a trigger on
// any valid symbol.
module channel_err_injector #(
   parameter int unsigned SYM_W     = 2,
   parameter int unsigned RATE_BITS = 3,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned CNT_W     = 32
) (
   input logic                   clk,
   input logic                   rst,
   channel_err_injector_if.slave bus_io
);

   // An all-zero LFSR would lock up.
   localparam logic [15:0]      SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [SYM_W-1:0] MsbHot  = {1'b1, {(SYM_W-1){1'b0}}};

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           st_q, st_d;
   logic [3:0]       rem_q, rem_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             valid_q;
   logic [SYM_W-1:0] sym_q, sym_d;
   logic [SYM_W-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] sym_ct_q, sym_ct_d;
   logic [CNT_W-1:0] bit_ct_q, bit_ct_d;

   logic             trig;
   logic [SYM_W-1:0] field;
   logic [CNT_W:0]   pop;
   logic [CNT_W:0]   bit_sum;

   always_comb begin
`ifdef ERR_INJ_FORCE_EN
      trig = bus_io.valid_i && ((&lfsr_q[RATE_BITS-1:0]) || bus_io.force_i);
`else
      trig = bus_io.valid_i && (&lfsr_q[RATE_BITS-1:0]);
`endif
      field = lfsr_q[RATE_BITS +: SYM_W];

      st_d   = st_q;
      rem_d  = rem_q;
      lfsr_d = lfsr_q;
      mask_d = mask_q;
      sym_d  = sym_q;

      if (bus_io.valid_i) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         mask_d = '0;
         // Any mode other than burst aborts a running burst on this symbol.
         st_d   = StIdle;
         rem_d  = 4'd0;
         unique case (bus_io.mode_i)
            2'd0: ;
            2'd1: if (trig) mask_d = MsbHot;
            2'd2: if (trig) mask_d = (field == '0) ? MsbHot : field;
            2'd3: begin
               if (st_q == StBurst) begin
                  // Triggers inside a burst are ignored.
                  mask_d = MsbHot;
                  rem_d  = rem_q - 4'd1;
                  st_d   = (rem_d == 4'd0) ? StIdle : StBurst;
               end else if (trig) begin
                  mask_d = MsbHot;
                  rem_d  = (bus_io.burst_len_i == 4'd0) ? 4'd0 : bus_io.burst_len_i - 4'd1;
                  st_d   = (rem_d == 4'd0) ? StIdle : StBurst;
               end
            end
         endcase
         sym_d = bus_io.sym_i ^ mask_d;
      end
   end

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < SYM_W; i++) begin
         pop = pop + {{CNT_W{1'b0}}, mask_d[i]};
      end
      bit_sum  = {1'b0, bit_ct_q} + pop;
      sym_ct_d = sym_ct_q;
      bit_ct_d = bit_ct_q;
      if (bus_io.clr_i) begin
         sym_ct_d = '0;
         bit_ct_d = '0;
      end else if (bus_io.valid_i) begin
         sym_ct_d = sym_ct_q + {{(CNT_W-1){1'b0}}, 1'b1};
         bit_ct_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q     <= StIdle;
         rem_q    <= 4'd0;
         lfsr_q   <= SeedEff;
         valid_q  <= 1'b0;
         sym_q    <= '0;
         mask_q   <= '0;
         sym_ct_q <= '0;
         bit_ct_q <= '0;
      end else begin
         st_q     <= st_d;
         rem_q    <= rem_d;
         lfsr_q   <= lfsr_d;
         valid_q  <= bus_io.valid_i;
         sym_q    <= sym_d;
         mask_q   <= mask_d;
         sym_ct_q <= sym_ct_d;
         bit_ct_q <= bit_ct_d;
      end
   end

   assign bus_io.valid_o      = valid_q;
   assign bus_io.sym_o        = sym_q;
   assign bus_io.err_mask_o   = mask_q;
   assign bus_io.sym_ct_o     = sym_ct_q;
   assign bus_io.bit_err_ct_o = bit_ct_q;

endmodule

// File: tb/tb_channel_err_injector.sv
module tb_channel_err_injector;

   localparam int unsigned SymW     = 2;
   localparam int unsigned RateBits = 3;

   logic clk = 1'b0;
   logic rst;
   logic frc;
   always #5 clk = ~clk;

   channel_err_injector_if #(.SYM_W(SymW), .CNT_W(32)) bus ();
   channel_err_injector_if #(.SYM_W(SymW), .CNT_W(4))  bus4 ();

   assign bus4.valid_i     = bus.valid_i;
   assign bus4.sym_i       = bus.sym_i;
   assign bus4.mode_i      = bus.mode_i;
   assign bus4.burst_len_i = bus.burst_len_i;
   assign bus4.clr_i       = bus.clr_i;
`ifdef ERR_INJ_FORCE_EN
   assign bus.force_i  = frc;
   assign bus4.force_i = frc;
`endif

   channel_err_injector #(
      .SYM_W(SymW), .RATE_BITS(RateBits), .SEED(16'hACE1), .CNT_W(32)
   ) u_dut (
      .clk(clk), .rst(rst), .bus_io(bus.slave)
   );

   channel_err_injector #(
      .SYM_W(SymW), .RATE_BITS(RateBits), .SEED(16'hACE1), .CNT_W(4)
   ) u_dut4 (
      .clk(clk), .rst(rst), .bus_io(bus4.slave)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Reference model state
   logic [15:0] m_lfsr;
   int          m_left;
   longint      m_sym, m_bit;
   int          m_sym4, m_bit4;
   logic        e_valid;
   logic [1:0]  e_sym, e_mask;
   int          trig_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One step of x^16+x^14+x^13+x^11+1 in Fibonacci form, shifting toward the MSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      int  taps [4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      foreach (taps[k]) fb = fb ^ l[taps[k]-1];
      return {l[14:0], fb};
   endfunction

   function automatic bit lfsr_trig(input logic [15:0] l);
      return (l & 16'h0007) == 16'h0007;
   endfunction

   task automatic model_reset();
      m_lfsr = 16'hACE1;
      m_left = 0;
      m_sym = 0; m_bit = 0; m_sym4 = 0; m_bit4 = 0;
      e_valid = 1'b0; e_sym = '0; e_mask = '0;
   endtask

   task automatic model(input logic v, input logic [1:0] s, input logic [1:0] md,
                        input logic [3:0] bl, input logic c, input logic f);
      bit         trig;
      logic [1:0] mask = '0;
      int         pop;
      trig = v && lfsr_trig(m_lfsr);
`ifdef ERR_INJ_FORCE_EN
      trig = trig || (v && f);
`else
      if (f) trig = trig;
`endif
      if (v) begin
         if (md == 2'd3) begin
            if (m_left > 0) begin
               mask = 2'b10;
               m_left--;
            end else if (trig) begin
               mask = 2'b10;
               m_left = ((bl == 0) ? 1 : int'(bl)) - 1;
            end
         end else begin
            m_left = 0;
            if (md == 2'd1 && trig) mask = 2'b10;
            if (md == 2'd2 && trig) begin
               mask = 2'((m_lfsr >> RateBits) & 16'h3);
               if (mask == 2'b00) mask = 2'b10;
            end
         end
         if (trig) trig_cnt++;
         m_lfsr = lfsr_step(m_lfsr);
         e_sym  = s ^ mask;
         e_mask = mask;
      end
      e_valid = v;
      pop = $countones(mask);
      if (c) begin
         m_sym = 0; m_bit = 0; m_sym4 = 0; m_bit4 = 0;
      end else if (v) begin
         m_sym  = (m_sym + 1) % 64'h1_0000_0000;
         m_bit  = (m_bit + pop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bit + pop;
         m_sym4 = (m_sym4 + 1) % 16;
         m_bit4 = (m_bit4 + pop > 15) ? 15 : m_bit4 + pop;
      end
   endtask

   // Drive at the falling edge, check 1 time unit after the following rising edge.
   task automatic cycle(input logic v, input logic [1:0] s, input logic [1:0] md,
                        input logic [3:0] bl, input logic c, input logic f);
      bus.valid_i = v; bus.sym_i = s; bus.mode_i = md;
      bus.burst_len_i = bl; bus.clr_i = c; frc = f;
      model(v, s, md, bl, c, f);
      @(posedge clk);
      #1;
      chk("valid", bus.valid_o, e_valid);
      chk("sym", bus.sym_o, e_sym);
      chk("mask", bus.err_mask_o, e_mask);
      chk("sym_ct", bus.sym_ct_o, m_sym);
      chk("bit_ct", bus.bit_err_ct_o, m_bit);
      chk("valid4", bus4.valid_o, e_valid);
      chk("sym_ct4", bus4.sym_ct_o, m_sym4);
      chk("bit_ct4", bus4.bit_err_ct_o, m_bit4);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, bus.valid_o, 0);
      chk({tag, "_sym"}, bus.sym_o, 0);
      chk({tag, "_mask"}, bus.err_mask_o, 0);
      chk({tag, "_symct"}, bus.sym_ct_o, 0);
      chk({tag, "_bitct"}, bus.bit_err_ct_o, 0);
      chk({tag, "_bitct4"}, bus4.bit_err_ct_o, 0);
   endtask

   // Run burst-mode symbols until a burst of more than one symbol is in flight.
   task automatic start_burst(input logic [3:0] bl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         cycle(1'b1, 2'($urandom), 2'd3, bl, 1'b0, 1'b0);
         ok = (m_left > 0);
      end
      chk("burst_started", 64'(ok), 1);
   endtask

   initial begin
      bit         ok;
      longint     b0;
      logic [1:0] s;

      rst = 1'b0;
      bus.valid_i = 1'b0; bus.sym_i = '0; bus.mode_i = '0;
      bus.burst_len_i = '0; bus.clr_i = 1'b0; frc = 1'b0;
      model_reset();
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Mode 0: alternating pattern passes unchanged
      for (int i = 0; i < 200; i++) cycle(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 2'd0, 4'd0, 1'b0, 1'b0);
      chk("m0_symct", bus.sym_ct_o, 200);
      chk("m0_bitct", bus.bit_err_ct_o, 0);

      // Mode 1: MSB flips at LFSR triggers; bit count equals trigger count
      cycle(1'b0, 2'b00, 2'd1, 4'd0, 1'b1, 1'b0);
      trig_cnt = 0;
      for (int i = 0; i < 256; i++) cycle(1'b1, 2'($urandom), 2'd1, 4'd0, 1'b0, 1'b0);
      chk("m1_trigcount", bus.bit_err_ct_o, 64'(trig_cnt));

      // Mode 3: random lengths (including 0), lengths changing mid-burst
      for (int i = 0; i < 400; i++)
         cycle(1'b1, 2'($urandom), 2'd3, 4'($urandom_range(0, 6)), 1'b0, 1'b0);

`ifdef ERR_INJ_FORCE_EN
      // Forced length-4 burst, second force inside it must not extend it
      for (int i = 0; i < 20; i++) cycle(1'b1, 2'b00, 2'd0, 4'd0, 1'b0, 1'b0);
      b0 = m_bit;
      cycle(1'b1, 2'b00, 2'd3, 4'd4, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 2'd3, 4'd4, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 2'd3, 4'd4, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 2'd3, 4'd4, 1'b0, 1'b0);
      chk("force_burst_bits", bus.bit_err_ct_o, 64'(b0 + 4));
      cycle(1'b1, 2'b00, 2'd0, 4'd0, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 2'd3, 4'd0, 1'b0, 1'b1);
      chk("force_len0_mask", bus.err_mask_o, 2'b10);
      cycle(1'b1, 2'b00, 2'd3, 4'd0, 1'b0, 1'b0);
      chk("force_len0_end", bus.err_mask_o, 64'(e_mask));
`endif

      // Burst aborted by a mode change
      start_burst(4'd8, ok);
      cycle(1'b1, 2'b01, 2'd3, 4'd8, 1'b0, 1'b0);
      cycle(1'b1, 2'b01, 2'd0, 4'd8, 1'b0, 1'b0);
      chk("abort_mask", bus.err_mask_o, 0);
      chk("abort_sym", bus.sym_o, 2'b01);

      // Mode 2 with 1-of-3 valid duty
      cycle(1'b0, 2'b00, 2'd2, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) cycle(i % 3 == 0, 2'($urandom), 2'd2, 4'd0, 1'b0, 1'b0);
      chk("gap_symct", bus.sym_ct_o, 100);

      // Clear coincident with an injection
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (lfsr_trig(m_lfsr)) begin
            cycle(1'b1, 2'b00, 2'd2, 4'd0, 1'b1, 1'b0);
            chk("clr_inj_mask_nz", 64'(bus.err_mask_o != 0), 1);
            chk("clr_inj_symct", bus.sym_ct_o, 0);
            chk("clr_inj_bitct", bus.bit_err_ct_o, 0);
            ok = 1'b1;
         end else begin
            cycle(1'b1, 2'b00, 2'd2, 4'd0, 1'b0, 1'b0);
         end
      end
      chk("clr_inj_found", 64'(ok), 1);

      // 4-bit counter saturates under long bursts
      for (int i = 0; i < 200; i++) cycle(1'b1, 2'($urandom), 2'd3, 4'd15, 1'b0, 1'b0);
      chk("sat4", bus4.bit_err_ct_o, 15);

      // Random mix of everything
      for (int i = 0; i < 400; i++) begin
         s = 2'($urandom);
         cycle($urandom_range(0, 3) != 0, s, 2'($urandom), 4'($urandom),
               $urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0);
      end

      // Reset in the middle of a burst
      start_burst(4'd15, ok);
      rst = 1'b0;
      #1;
      check_zero("midburst_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 64; i++) cycle(1'b1, 2'($urandom), 2'd1, 4'd0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/channel_err_injector.md
Name: channel_err_injector

Overview:
- Parametrised channel model between the convolutional encoder output and the Viterbi decoder input.
- Injects bit errors into SYM_W-bit encoded symbols under an LFSR-driven trigger.
- Three run-time modes: single-bit, random-mask and burst.
- Keeps symbol and bit-error statistics, so BER runs need no bench-side error counting.

Parameters:
- SYM_W, 2, encoded symbol width (code rate 1/SYM_W); legal 2..8.
- RATE_BITS, 3, trigger fires when lfsr[RATE_BITS-1:0] is all ones, i.e. probability 2^-RATE_BITS per symbol; legal 1..8.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-low reset.
- valid_i, input, 1, sym_i is valid this cycle.
- sym_i, input, SYM_W, clean encoder symbol.
- mode_i, input, 2, 0 = pass-through, 1 = single-bit, 2 = random mask, 3 = burst.
- burst_len_i, input, 4, burst length in symbols (mode 3).
- clr_i, input, 1, synchronous clear of the statistics counters.
- valid_o, output, 1, registered copy of valid_i.
- sym_o, output, SYM_W, sym_i XOR err_mask_o.
- err_mask_o, output, SYM_W, mask applied to the current sym_o.
- sym_ct_o, output, CNT_W, valid symbols passed; wraps.
- bit_err_ct_o, output, CNT_W, total flipped bits; saturates at all ones.

Behaviour:
- Reset (rst low, async): valid_o, sym_o, err_mask_o, sym_ct_o and bit_err_ct_o all 0; lfsr = SEED (or 1); FSM = IDLE; burst counter = 0.
- Latency: exactly 1 cycle from valid_i/sym_i to valid_o/sym_o.
- When valid_i = 0: valid_o = 0, sym_o and err_mask_o hold their last values, LFSR and counters hold.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances by one step only on cycles with valid_i = 1. The pre-advance value is used for that symbol.
- Trigger: trig = valid_i and (lfsr[RATE_BITS-1:0] == all ones).
- Mode 0: mask = 0; LFSR still advances.
- Mode 1: if trig, mask = one-hot at bit SYM_W-1 (MSB flip); otherwise 0.
- Mode 2: if trig, mask = lfsr[RATE_BITS+SYM_W-1:RATE_BITS]. A zero field is replaced by the MSB one-hot, so a trigger always flips at least one bit.
- Mode 3 FSM, states IDLE and BURST:
  - IDLE with trig: mask = MSB one-hot, rem = eff_len-1, where eff_len = max(burst_len_i, 1). Go to BURST if rem > 0, else stay in IDLE.
  - BURST on each valid symbol: mask = MSB one-hot, rem decrements, return to IDLE when rem reaches 0. Triggers during BURST are ignored (no re-extension).
  - burst_len_i is sampled only on the IDLE->BURST trigger; later changes do not affect a running burst.
  - If mode_i != 3 while in BURST: burst aborts, FSM goes to IDLE, and that symbol follows the new mode's rule.
- Counters, on each valid symbol:
  - sym_ct_o += 1, wrapping modulo 2^CNT_W.
  - bit_err_ct_o += popcount(mask), saturating at 2^CNT_W-1.
  - clr_i has priority: when asserted, both counters become 0 that cycle, even with valid_i = 1. LFSR and FSM are unaffected.
- Reset mid-burst: FSM returns to IDLE, any in-flight output is dropped, LFSR reloads SEED.

Optional Feature:
- Macro: ERR_INJ_FORCE_EN.
- Defined: adds input port force_i (1 bit). force_i = 1 with valid_i = 1 forces trig = 1 regardless of the LFSR. The LFSR still advances normally, and all mode rules apply unchanged.
- Undefined: port absent; trigger comes from the LFSR only.

Test Plan:
- Mode 0, 200 symbols of alternating 2'b01/2'b10 -> sym_o == sym_i delayed 1 cycle, err_mask_o always 0, sym_ct_o = 200, bit_err_ct_o = 0.
- Mode 1, RATE_BITS = 3, SEED = 16'hACE1, 256 symbols -> each sym_o MSB is flipped exactly where the bench golden LFSR model gives lfsr[2:0] = 3'b111; bit_err_ct_o equals the model's trigger count.
- Mode 3, burst_len_i = 4 (with force_i if ERR_INJ_FORCE_EN is defined) -> 4 consecutive valid symbols have MSB flipped and bit_err_ct_o += 4. A second trigger inside the burst does not extend it. burst_len_i = 0 gives a 1-symbol burst.
- Mode 3 burst running, switch mode_i to 0 after 2 symbols -> next symbol err_mask_o = 0 and FSM is IDLE.
- valid_i gaps (1-of-3 duty) in mode 2 -> mask sequence identical to the continuous-valid run; valid_o never asserts in gap cycles; sym_ct_o counts only valid symbols.
- clr_i coincident with valid_i and an injection -> both counters read 0 next cycle.
- CNT_W = 4 with a forced error every symbol -> bit_err_ct_o sticks at 15.
- rst pulsed mid-burst -> all outputs 0, after which the first trigger matches the SEED-based model.
